fp_mantis_adder_pipe: RTL and testbench

- Pipelined, parametrised significand add/subtract unit for the floating-point datapath.
- Sits after exponent alignment and before rounding. Accepts two aligned mantissas with a common exponent.
- Produces a fully normalised result: carry right-shift or leading-zero left-shift.
- Adds magnitude swap, zero/overflow/underflow flags and a valid/ready handshake with backpressure.

---
 rtl/fp_mantis_adder_pipe.sv | 183 ++++++++++++++++++
 tb/tb_fp_mantis_adder_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mantis_adder_pipe.sv
// Purpose : significand add/subtract with magnitude swap, carry/leading-zero normalisation and flags.
// Latency : 3 register stages; the result is valid on the 3rd edge counting the accepting edge as the 1st.
// Backpressure: a stage advances when it is empty or the next stage advances; in_ready = stage-1 advance.
// Ports   : clk/rst (sync, active-high); in_valid/in_ready + sign_A/sign_B/exp/mantis_A/mantis_B operands;
//           out_valid/out_ready + sign/exp_out/mantis_out result and operator/loss/zero/overflow/underflow flags.
module fp_mantis_adder_pipe #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 28
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sign_A,
  input  logic             sign_B,
  input  logic [EXP_W-1:0] exp,
  input  logic [MAN_W-1:0] mantis_A,
  input  logic [MAN_W-1:0] mantis_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             sign,
  output logic [EXP_W-1:0] exp_out,
  output logic [MAN_W-1:0] mantis_out,
  output logic             operator,
  output logic             loss,
  output logic             zero,
  output logic             overflow,
  output logic             underflow
);

  localparam int LZ_W  = $clog2(MAN_W + 1);
  // Wide enough to compare a leading-zero count against an exponent without truncation.
  localparam int CMP_W = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 1;

  typedef struct packed {
    logic             sign;
    logic             op;
    logic [EXP_W-1:0] exp;
    logic [MAN_W:0]   sum;   // one extra bit catches the add carry
  } s1_t;

  typedef struct packed {
    logic             sign;
    logic             op;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
    logic             loss;
    logic             ovf;
  } s2_t;

  typedef struct packed {
    logic             sign;
    logic             op;
    logic [EXP_W-1:0] exp;
    logic [MAN_W-1:0] man;
    logic             loss;
    logic             zero;
    logic             ovf;
    logic             unf;
  } s3_t;

  logic s1_vld_q, s1_vld_d;
  logic s2_vld_q, s2_vld_d;
  logic s3_vld_q, s3_vld_d;
  s1_t  s1_dat_q, s1_dat_d;
  s2_t  s2_dat_q, s2_dat_d;
  s3_t  s3_dat_q, s3_dat_d;

  logic            s1_adv, s2_adv, s3_adv;
  logic [LZ_W-1:0] lz;

  // Leading-zero count of the stage-2 mantissa; the highest set bit is visited last and wins.
  always_comb begin
    lz = LZ_W'(MAN_W);
    for (int i = 0; i < MAN_W; i++) begin
      if (s2_dat_q.man[i]) lz = LZ_W'(MAN_W - 1 - i);
    end
  end

  always_comb begin
    s3_adv   = !s3_vld_q || out_ready;
    s2_adv   = !s2_vld_q || s3_adv;
    s1_adv   = !s1_vld_q || s2_adv;
    in_ready = s1_adv;

    // Stage 1: add or magnitude-ordered subtract, so the result is never negative.
    s1_vld_d = s1_adv ? in_valid : s1_vld_q;
    s1_dat_d = s1_dat_q;
    if (s1_adv && in_valid) begin
      s1_dat_d.op  = sign_A ^ sign_B;
      s1_dat_d.exp = exp;
      if (!(sign_A ^ sign_B)) begin
        s1_dat_d.sum  = {1'b0, mantis_A} + {1'b0, mantis_B};
        s1_dat_d.sign = sign_A;
      end else if (mantis_B > mantis_A) begin
        s1_dat_d.sum  = {1'b0, mantis_B} - {1'b0, mantis_A};
        s1_dat_d.sign = sign_B;
      end else begin
        s1_dat_d.sum  = {1'b0, mantis_A} - {1'b0, mantis_B};
        s1_dat_d.sign = sign_A;
      end
    end

    // Stage 2: fold a carry back into MAN_W bits; the exponent saturates at all-ones.
    s2_vld_d = s2_adv ? s1_vld_q : s2_vld_q;
    s2_dat_d = s2_dat_q;
    if (s2_adv && s1_vld_q) begin
      s2_dat_d.sign = s1_dat_q.sign;
      s2_dat_d.op   = s1_dat_q.op;
      s2_dat_d.exp  = s1_dat_q.exp;
      s2_dat_d.loss = 1'b0;
      s2_dat_d.ovf  = 1'b0;
      if (s1_dat_q.sum[MAN_W]) begin
        s2_dat_d.man  = s1_dat_q.sum[MAN_W:1];
        s2_dat_d.loss = s1_dat_q.sum[0];
        if (&s1_dat_q.exp) s2_dat_d.ovf = 1'b1;
        else               s2_dat_d.exp = s1_dat_q.exp + 1'b1;
      end else begin
        s2_dat_d.man = s1_dat_q.sum[MAN_W-1:0];
      end
    end

    // Stage 3: left-normalise subtract results, never driving the exponent below 0.
    s3_vld_d = s3_adv ? s2_vld_q : s3_vld_q;
    s3_dat_d = s3_dat_q;
    if (s3_adv && s2_vld_q) begin
      s3_dat_d.sign = s2_dat_q.sign;
      s3_dat_d.op   = s2_dat_q.op;
      s3_dat_d.exp  = s2_dat_q.exp;
      s3_dat_d.man  = s2_dat_q.man;
      s3_dat_d.loss = s2_dat_q.loss;
      s3_dat_d.ovf  = s2_dat_q.ovf;
      s3_dat_d.zero = 1'b0;
      s3_dat_d.unf  = 1'b0;
      if (s2_dat_q.man == '0) begin
        // Exact zero is canonical: positive sign, zero exponent, no flags.
        s3_dat_d.sign = 1'b0;
        s3_dat_d.exp  = '0;
        s3_dat_d.loss = 1'b0;
        s3_dat_d.ovf  = 1'b0;
        s3_dat_d.zero = 1'b1;
      end else if (s2_dat_q.op) begin
        if (CMP_W'(lz) <= CMP_W'(s2_dat_q.exp)) begin
          s3_dat_d.man = s2_dat_q.man << lz;
          s3_dat_d.exp = s2_dat_q.exp - EXP_W'(lz);
        end else begin
          s3_dat_d.man = s2_dat_q.man << s2_dat_q.exp;
          s3_dat_d.exp = '0;
          s3_dat_d.unf = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s3_vld_q <= 1'b0;
      s1_dat_q <= '0;
      s2_dat_q <= '0;
      s3_dat_q <= '0;
    end else begin
      s1_vld_q <= s1_vld_d;
      s2_vld_q <= s2_vld_d;
      s3_vld_q <= s3_vld_d;
      s1_dat_q <= s1_dat_d;
      s2_dat_q <= s2_dat_d;
      s3_dat_q <= s3_dat_d;
    end
  end

  assign out_valid  = s3_vld_q;
  assign sign       = s3_dat_q.sign;
  assign exp_out    = s3_dat_q.exp;
  assign mantis_out = s3_dat_q.man;
  assign operator   = s3_dat_q.op;
  assign loss       = s3_dat_q.loss;
  assign zero       = s3_dat_q.zero;
  assign overflow   = s3_dat_q.ovf;
  assign underflow  = s3_dat_q.unf;

endmodule

// File: tb/tb_fp_mantis_adder_pipe.sv
// Purpose : self-checking bench for fp_mantis_adder_pipe (EXP_W=8, MAN_W=28).
// Latency : expects out_valid on the 3rd edge counting the accepting edge; scoreboard tracks order.
// Backpressure: exercises stalls with out_ready low and checks results stay correct while held.
module tb_fp_mantis_adder_pipe;

  localparam int EXP_W = 8;
  localparam int MAN_W = 28;

  typedef struct packed {
    logic       sign;
    logic       op;
    logic [7:0] exp;
    logic [27:0] man;
    logic       loss;
    logic       zero;
    logic       ovf;
    logic       unf;
  } res_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        sign_A;
  logic        sign_B;
  logic [7:0]  exp;
  logic [27:0] mantis_A;
  logic [27:0] mantis_B;
  logic        out_valid;
  logic        out_ready;
  logic        sign;
  logic [7:0]  exp_out;
  logic [27:0] mantis_out;
  logic        operator;
  logic        loss;
  logic        zero;
  logic        overflow;
  logic        underflow;

  int tests = 0;
  int fails = 0;
  res_t exp_q[$];

  fp_mantis_adder_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign_A(sign_A), .sign_B(sign_B), .exp(exp),
    .mantis_A(mantis_A), .mantis_B(mantis_B),
    .out_valid(out_valid), .out_ready(out_ready),
    .sign(sign), .exp_out(exp_out), .mantis_out(mantis_out),
    .operator(operator), .loss(loss), .zero(zero),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer arithmetic, then normalise one bit at a time.
  function automatic res_t model(input logic sa, input logic sb, input logic [7:0] e,
                                 input logic [27:0] a, input logic [27:0] b);
    res_t   r;
    longint s;
    int     ex;
    r    = '0;
    r.op = sa ^ sb;
    ex   = int'(e);
    if (!r.op) begin
      s = longint'(a) + longint'(b);
      r.sign = sa;
    end else if (b > a) begin
      s = longint'(b) - longint'(a);
      r.sign = sb;
    end else begin
      s = longint'(a) - longint'(b);
      r.sign = sa;
    end
    if (s == 0) begin
      r.sign = 1'b0;
      r.zero = 1'b1;
      return r;
    end
    if (s >= (64'd1 << 28)) begin
      r.loss = s[0];
      s = s >> 1;
      if (ex == 255) r.ovf = 1'b1;
      else           ex = ex + 1;
    end
    if (r.op) begin
      while (s < (64'd1 << 27) && ex > 0) begin
        s  = s << 1;
        ex = ex - 1;
      end
      if (s < (64'd1 << 27)) r.unf = 1'b1;
    end
    r.man = s[27:0];
    r.exp = ex[7:0];
    return r;
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  function automatic res_t dut_res();
    return {sign, operator, exp_out, mantis_out, loss, zero, overflow, underflow};
  endfunction

  // Scoreboard: every cycle a result is presented it must match the oldest outstanding operation.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("stale_result", 64'(out_valid), 64'd0);
        end else begin
          chk("scoreboard", 64'(dut_res()), 64'(exp_q[0]));
          if (out_ready) void'(exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(sign_A, sign_B, exp, mantis_A, mantis_B));
    end
  end

  // Present one operation and hold it until accepted; waited counts stalled cycles.
  task automatic send(input logic sa, input logic sb, input logic [7:0] e,
                      input logic [27:0] a, input logic [27:0] b, output int waited);
    sign_A = sa; sign_B = sb; exp = e; mantis_A = a; mantis_B = b;
    in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic vec(input string nm, input logic sa, input logic sb, input logic [7:0] e,
                     input logic [27:0] a, input logic [27:0] b, input res_t want);
    int waited;
    int n;
    chk({nm, "_model"}, 64'(model(sa, sb, e, a, b)), 64'(want));
    send(sa, sb, e, a, b, waited);
    n = 1;
    @(negedge clk);
    while (!out_valid && n < 10) begin
      n++;
      @(negedge clk);
    end
    chk({nm, "_latency"}, 64'(n), 64'd3);
    chk({nm, "_result"}, 64'(dut_res()), 64'(want));
    @(posedge clk);
    #1;
  endtask

  // Hand-computed expectations: {sign, op, exp, man, loss, zero, ovf, unf}
  initial begin
    int w;
    int t;
    logic [27:0] ba[8];
    logic [27:0] bb[8];
    logic [7:0]  be[8];
    ba = '{28'h8000000, 28'h0123456, 28'hFFFFFFF, 28'h4000000, 28'h0000001, 28'h7654321, 28'hABCDEF0, 28'h0F0F0F0};
    bb = '{28'h0000001, 28'h0123456, 28'h0000001, 28'h3FFFFFF, 28'h0000002, 28'h1234567, 28'hABCDEF1, 28'h00F0F0F};
    be = '{8'h80, 8'h10, 8'hFF, 8'h03, 8'h1A, 8'h00, 8'h40, 8'h07};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    sign_A = 1'b0; sign_B = 1'b0; exp = '0; mantis_A = '0; mantis_B = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_data", 64'(dut_res()), 64'd0);
    @(posedge clk); #1;

    vec("add_noloss", 0, 0, 8'h10, 28'h8000000, 28'h8000000, {1'b0, 1'b0, 8'h11, 28'h8000000, 4'b0000});
    vec("add_loss1",  0, 0, 8'h10, 28'h8000001, 28'h8000000, {1'b0, 1'b0, 8'h11, 28'h8000000, 4'b1000});
    vec("add_loss2",  0, 0, 8'h10, 28'h8000000, 28'hFFFFFFF, {1'b0, 1'b0, 8'h11, 28'hBFFFFFF, 4'b1000});
    vec("sub_swap",   0, 1, 8'h10, 28'h4000000, 28'h8000000, {1'b1, 1'b1, 8'h0F, 28'h8000000, 4'b0000});
    vec("sub_unf",    0, 1, 8'h00, 28'h4000000, 28'h8000000, {1'b1, 1'b1, 8'h00, 28'h4000000, 4'b0001});
    vec("sub_zero",   0, 1, 8'h20, 28'h5555555, 28'h5555555, {1'b0, 1'b1, 8'h00, 28'h0000000, 4'b0100});
    vec("add_ovf",    0, 0, 8'hFF, 28'h8000000, 28'h8000000, {1'b0, 1'b0, 8'hFF, 28'h8000000, 4'b0010});
    vec("sub_lz_eq",  1, 0, 8'h02, 28'h4000000, 28'h2000000, {1'b1, 1'b1, 8'h00, 28'h8000000, 4'b0000});
    vec("sub_norm",   1, 0, 8'h40, 28'hC000000, 28'h1000000, {1'b1, 1'b1, 8'h40, 28'hB000000, 4'b0000});
    vec("add_nocarry",1, 1, 8'h05, 28'h1000000, 28'h1000000, {1'b1, 1'b0, 8'h05, 28'h2000000, 4'b0000});

    // Full-rate burst: every operation must be accepted without a stall.
    for (int i = 0; i < 8; i++) begin
      send(i[0], i[1], be[i], ba[i], bb[i], w);
      chk("burst_no_stall", 64'(w), 64'd0);
    end
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin @(negedge clk); t++; end
    chk("burst_drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;

    // Backpressure: out_ready low for 6 cycles while 4 operations are offered.
    fork
      begin
        out_ready = 1'b0;
        repeat (6) @(posedge clk);
        #1 out_ready = 1'b1;
      end
      begin
        for (int i = 0; i < 4; i++) begin
          send(1'b0, i[0], 8'h20 + 8'(i), 28'h8000000 + 28'(i * 3), 28'h0400000 + 28'(i), w);
          if (i < 3) chk("bp_accept", 64'(w), 64'd0);
          else       chk("bp_fourth_stalls", 64'(w != 0), 64'd1);
        end
      end
    join
    t = 0;
    while (exp_q.size() != 0 && t < 20) begin @(negedge clk); t++; end
    chk("bp_drain", 64'(exp_q.size()), 64'd0);
    @(posedge clk); #1;

    // Reset with two operations in flight: nothing may emerge afterwards.
    send(1'b0, 1'b0, 8'h30, 28'h9000000, 28'h9000000, w);
    send(1'b0, 1'b1, 8'h30, 28'h9000000, 28'h1000000, w);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_mantis", 64'(mantis_out), 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_no_stale", 64'(out_valid), 64'd0);
    end

    // Post-reset sanity: the pipe still produces correct results.
    @(posedge clk); #1;
    vec("post_rst", 0, 0, 8'h10, 28'h8000000, 28'h8000000, {1'b0, 1'b0, 8'h11, 28'h8000000, 4'b0000});
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
